// File: rtl/reset_sequencer.sv
// Reset sequencer: holds every reset domain after power-on, a debounced button press
// or a software request, then releases the domains one at a time, bit 0 first.
module reset_sequencer #(
    parameter int CYCLES    = 20,
    parameter int CHANNELS  = 3,
    parameter int STAGE_GAP = 4,
    parameter int DEBOUNCE  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_n,
    input  logic                soft_rst_req,
    output logic [CHANNELS-1:0] resetn_o,
    output logic                done,
    output logic [1:0]          cause
);

    localparam int CNT_MAX = (CYCLES > STAGE_GAP) ? CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DB_W    = $clog2(DEBOUNCE + 1);
    localparam int STG_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    // With no gap (or a single channel) everything releases together and RELEASE is skipped.
    localparam bit DIRECT  = (STAGE_GAP == 0) || (CHANNELS == 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    logic                sync1_r;
    logic                sync2_r;
    logic                db_r;
    logic [DB_W-1:0]     db_cnt_r;
    logic                btn_trig_r;
    logic                soft_trig_r;
    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    logic [STG_W-1:0]    stg_r;
    logic [STG_W-1:0]    stg_s;
    logic [CHANNELS-1:0] resetn_r;
    logic [CHANNELS-1:0] resetn_s;
    logic                done_r;
    logic                done_s;
    logic [1:0]          cause_r;
    logic [1:0]          cause_s;
    logic                trig_s;
    logic                hold_done_s;
    logic                gap_done_s;
    logic                last_stg_s;

    // Button synchronizer and debouncer; btn_trig_r pulses for one cycle after a debounced fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r    <= 1'b1;
            sync2_r    <= 1'b1;
            db_r       <= 1'b1;
            db_cnt_r   <= '0;
            btn_trig_r <= 1'b0;
        end else begin
            sync1_r <= btn_n;
            sync2_r <= sync1_r;
            if (sync2_r == db_r) begin
                db_cnt_r   <= '0;
                btn_trig_r <= 1'b0;
            end else if (db_cnt_r == DB_W'(DEBOUNCE - 1)) begin
                db_r       <= sync2_r;
                db_cnt_r   <= '0;
                btn_trig_r <= ~sync2_r;
            end else begin
                db_cnt_r   <= db_cnt_r + DB_W'(1);
                btn_trig_r <= 1'b0;
            end
        end
    end

    // Shared decode terms; a soft request is only honoured outside HOLD.
    always_comb begin
        trig_s      = btn_trig_r | (soft_trig_r & (state_r != HOLD));
        hold_done_s = db_r & ~btn_trig_r & (cnt_r == CNT_W'(CYCLES - 1));
        gap_done_s  = (cnt_r == CNT_W'(STAGE_GAP - 1));
        last_stg_s  = (stg_r == STG_W'(CHANNELS - 1));
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= HOLD;
            cnt_r       <= '0;
            stg_r       <= '0;
            resetn_r    <= '0;
            done_r      <= 1'b0;
            cause_r     <= 2'd0;
            soft_trig_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            stg_r       <= stg_s;
            resetn_r    <= resetn_s;
            done_r      <= done_s;
            cause_r     <= cause_s;
            soft_trig_r <= soft_rst_req & (state_r != HOLD);
        end
    end

    // Next-state and counter logic; the counter stays at 0 while the debounced button is down.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        stg_s   = stg_r;
        case (state_r)
            HOLD: begin
                if (btn_trig_r || !db_r) begin
                    cnt_s = '0;
                end else if (hold_done_s) begin
                    cnt_s   = '0;
                    stg_s   = STG_W'(1);
                    state_s = DIRECT ? RUN : RELEASE;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (trig_s) begin
                    state_s = HOLD;
                    cnt_s   = '0;
                    stg_s   = '0;
                end else if (gap_done_s) begin
                    cnt_s = '0;
                    stg_s = stg_r + STG_W'(1);
                    if (last_stg_s) begin
                        state_s = RUN;
                    end else begin
                        state_s = RELEASE;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            RUN: begin
                if (trig_s) begin
                    state_s = HOLD;
                    cnt_s   = '0;
                    stg_s   = '0;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = HOLD;
                cnt_s   = '0;
                stg_s   = '0;
            end
        endcase
    end

    // Next values of the registered outputs; the button wins over a simultaneous soft request.
    always_comb begin
        resetn_s = resetn_r;
        done_s   = done_r;
        cause_s  = cause_r;
        case (state_r)
            HOLD: begin
                if (btn_trig_r) begin
                    resetn_s = '0;
                    done_s   = 1'b0;
                    cause_s  = 2'd1;
                end else if (hold_done_s) begin
                    if (DIRECT) begin
                        resetn_s = {CHANNELS{1'b1}};
                        done_s   = 1'b1;
                    end else begin
                        resetn_s = CHANNELS'(1);
                    end
                end else begin
                    resetn_s = resetn_r;
                end
            end
            RELEASE, RUN: begin
                if (trig_s) begin
                    resetn_s = '0;
                    done_s   = 1'b0;
                    cause_s  = btn_trig_r ? 2'd1 : 2'd2;
                end else if ((state_r == RELEASE) && gap_done_s) begin
                    resetn_s = resetn_r | (CHANNELS'(1) << stg_r);
                    if (last_stg_s) begin
                        done_s = 1'b1;
                    end else begin
                        done_s = done_r;
                    end
                end else begin
                    resetn_s = resetn_r;
                end
            end
            default: begin
                resetn_s = '0;
                done_s   = 1'b0;
            end
        endcase
    end

    assign resetn_o = resetn_r;
    assign done     = done_r;
    assign cause    = cause_r;

endmodule
